// File: rtl/divider_restoring_seq.sv
`default_nettype none
// ============================================================================
// Module      : divider_restoring_seq
// Description : Sequential unsigned restoring divider, one quotient bit per
//               clock, using x + ~y + 1 trial subtraction with start/done.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_restoring_seq #(
    parameter int WIDTH = 4
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_start,
    output logic             out_busy,
    output logic             out_done,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_r,
    output logic             out_div0
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   prem;
    logic [CW-1:0]    step_cnt;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             carry;
    logic [WIDTH:0]   prem_next;
    logic [WIDTH-1:0] dividend_next;

    // Carry-out of P' + ~{0,D} + 1 is set exactly when P' >= D (no borrow).
    always_comb begin
        shifted       = {prem[WIDTH-1:0], dividend[WIDTH-1]};
        trial         = {1'b0, shifted} + {1'b0, ~{1'b0, divisor}}
                        + {{(WIDTH+1){1'b0}}, 1'b1};
        carry         = trial[WIDTH+1];
        prem_next     = carry ? trial[WIDTH:0] : shifted;
        dividend_next = {dividend[WIDTH-2:0], carry};
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state    <= ST_IDLE;
            dividend <= '0;
            divisor  <= '0;
            prem     <= '0;
            step_cnt <= '0;
            out_q    <= '0;
            out_r    <= '0;
            out_div0 <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (in_start) begin
                        if (in_y != '0) begin
                            state    <= ST_RUN;
                            dividend <= in_x;
                            divisor  <= in_y;
                            prem     <= '0;
                            step_cnt <= CW'(WIDTH - 1);
                            out_div0 <= 1'b0;
                        end else begin
                            state    <= ST_DONE;
                            out_q    <= '1;
                            out_r    <= in_x;
                            out_div0 <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    dividend <= dividend_next;
                    prem     <= prem_next;
                    if (step_cnt == '0) begin
                        state <= ST_DONE;
                        out_q <= dividend_next;
                        out_r <= prem_next[WIDTH-1:0];
                    end else begin
                        step_cnt <= step_cnt - CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_busy = (state == ST_RUN);
    assign out_done = (state == ST_DONE);

    // The partial remainder always stays below the divisor between steps.
    a_prem_no_overflow: assert property (@(posedge in_clk) disable iff (!in_rst_n)
        !prem[WIDTH]);

endmodule
`default_nettype wire

// File: tb/tb_divider_restoring_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_restoring_seq
// Description : Randomized self-checking bench against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_restoring_seq;

    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div0;

    int checks   = 0;
    int failures = 0;

    divider_restoring_seq #(.WIDTH(WIDTH)) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .in_x     (x),
        .in_y     (y),
        .in_start (start),
        .out_busy (busy),
        .out_done (done),
        .out_q    (q),
        .out_r    (r),
        .out_div0 (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to completion; noise drives extra
    // requests while busy, hold_check verifies the one-cycle done pulse.
    task automatic run_op(input int ax, input int ay, input bit noise,
                          input bit hold_check, output time done_time);
        int exp_q, exp_r, exp_d0, exp_edges, n, busy_cnt;
        exp_d0    = (ay == 0) ? 1 : 0;
        exp_q     = (ay == 0) ? MAXV : ax / ay;
        exp_r     = (ay == 0) ? ax : ax % ay;
        exp_edges = (ay == 0) ? 0 : WIDTH;
        @(negedge clk);
        x     = WIDTH'(ax);
        y     = WIDTH'(ay);
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        x        = WIDTH'($urandom);
        y        = WIDTH'($urandom);
        n        = 0;
        busy_cnt = 0;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            if (noise) begin
                start = busy;
                x     = 4'd1;
                y     = 4'd1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start     = 1'b0;
        done_time = $time;
        check("done_seen", done, 1);
        check("done_edges", n, exp_edges);
        check("busy_cycles", busy_cnt, exp_edges);
        check("busy_at_done", busy, 0);
        check("q", q, exp_q);
        check("r", r, exp_r);
        check("div0", div0, exp_d0);
        if (hold_check) begin
            @(posedge clk);
            #1;
            check("done_pulse", done, 0);
            check("q_hold", q, exp_q);
            check("r_hold", r, exp_r);
            check("div0_hold", div0, exp_d0);
        end
    endtask

    initial begin
        time t0, t1;
        rst_n = 1'b0;
        start = 1'b0;
        x     = '0;
        y     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_div0", div0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(13, 3, 1'b0, 1'b1, t0);
        // Back-to-back: second request accepted from DONE.
        run_op(15, 1, 1'b0, 1'b0, t0);
        run_op(2, 9, 1'b0, 1'b1, t1);
        check("b2b_spacing", 32'(t1 - t0), 32'((WIDTH + 1) * 10));
        run_op(7, 0, 1'b0, 1'b1, t0);
        run_op(6, 2, 1'b0, 1'b1, t0);
        run_op(9, 4, 1'b1, 1'b1, t0);

        // Asynchronous reset mid-RUN.
        @(negedge clk);
        x     = 4'd14;
        y     = 4'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_q", q, 0);
        check("arst_r", r, 0);
        check("arst_div0", div0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(14, 5, 1'b0, 1'b1, t0);

        for (int ix = 0; ix <= MAXV; ix++)
            for (int iy = 0; iy <= MAXV; iy++)
                run_op(ix, iy, 1'b0, 1'b0, t0);

        for (int k = 0; k < 40; k++)
            run_op(int'($urandom_range(MAXV, 0)), int'($urandom_range(MAXV, 0)),
                   1'($urandom), 1'($urandom), t0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
